// File: rtl/riscv.sv
// Core-wide RISC-V architectural constants shared by the verification helpers.
package riscv;
  localparam int unsigned XLEN = 64;
endpackage

// File: rtl/rvfi_pkg.sv
// RVFI commit-port record, exit classification and store-instruction decode.
package rvfi_pkg;

  localparam int unsigned XLEN = riscv::XLEN;

  typedef enum logic [1:0] {
    EXIT_NONE    = 2'd0,
    EXIT_TOHOST  = 2'd1,
    EXIT_TIMEOUT = 2'd2,
    EXIT_HANG    = 2'd3
  } exit_kind_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       insn;
    logic              trap;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_instr_t;

  // SW/SD in the base encoding, C.SW/C.SD (C.SD only on RV64) in quadrant 0.
  function automatic logic is_store(input logic [31:0] insn);
    logic base_st;
    logic rvc_st;
    base_st = (insn[6:0] == 7'b0100011) &&
              ((insn[14:12] == 3'b010) || (insn[14:12] == 3'b011));
    rvc_st  = (insn[1:0] == 2'b00) &&
              ((insn[15:13] == 3'b110) || ((insn[15:13] == 3'b111) && (XLEN == 64)));
    return base_st || rvc_st;
  endfunction

endpackage

// File: rtl/rvfi_tohost_port.sv
// Per-commit-port tohost watcher: remembers the last tohost write and flags a
// terminating store commit on this port.
module rvfi_tohost_port
  import rvfi_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] tohost_addr_i,
  input  rvfi_instr_t     rvfi_i,
  output logic            term_o,
  output logic [XLEN-1:0] code_o
);

  logic            hit;
  logic            pending;
  logic [XLEN-1:0] value;

  // The write is observed whether or not the commit is valid.
  assign hit = (rvfi_i.mem_addr == tohost_addr_i) && (tohost_addr_i != '0) &&
               (rvfi_i.mem_wmask != '0) && (rvfi_i.mem_wdata != '0);

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= 1'b0;
      value   <= '0;
    end else if (clear_i) begin
      pending <= 1'b0;
      value   <= '0;
    end else if (hit) begin
      pending <= 1'b1;
      value   <= rvfi_i.mem_wdata;
    end
  end

  assign term_o = rvfi_i.valid && is_store(rvfi_i.insn) && (pending || hit);
  assign code_o = hit ? rvfi_i.mem_wdata : value;

endmodule

// File: rtl/rvfi_exit_monitor.sv
// Watches RVFI commits and decides when a simulation run has ended (tohost
// write, cycle timeout or hang), while keeping cycle/instret/trap statistics.
module rvfi_exit_monitor
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned CNT_W           = 64,
  parameter int unsigned HANG_LIMIT      = 1000
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_i,
  input  logic [riscv::XLEN-1:0]             tohost_addr_i,
  input  logic [CNT_W-1:0]                   timeout_i,
  input  logic                               clear_i,
  output logic                               done_o,
  output exit_kind_e                         exit_kind_o,
  output logic [riscv::XLEN-1:0]             exit_code_o,
  output logic [riscv::XLEN-1:0]             exit_pc_o,
  output logic [CNT_W-1:0]                   cycles_o,
  output logic [CNT_W-1:0]                   instret_o,
  output logic [CNT_W-1:0]                   traps_o
);

  localparam logic [0:0]       ST_RUN  = 1'b0;
  localparam logic [0:0]       ST_DONE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]      state;
  logic [31:0]     hang_cnt;

  logic [NR_COMMIT_PORTS-1:0] port_term;
  logic [XLEN-1:0]            port_code [NR_COMMIT_PORTS];

  logic            tohost_fire;
  logic [XLEN-1:0] sel_code;
  logic [XLEN-1:0] sel_pc;
  logic [CNT_W-1:0] n_valid;
  logic [CNT_W-1:0] n_trap;
  logic            any_valid;
  logic            timeout_hit;
  logic            hang_hit;

  for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_port
    rvfi_tohost_port u_port (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .tohost_addr_i (tohost_addr_i),
      .rvfi_i        (rvfi_i[i]),
      .term_o        (port_term[i]),
      .code_o        (port_code[i])
    );
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    tohost_fire = 1'b0;
    sel_code    = '0;
    sel_pc      = '0;
    n_valid     = '0;
    n_trap      = '0;
    // Walk downwards so the lowest-index terminating port is the one kept.
    for (int i = int'(NR_COMMIT_PORTS) - 1; i >= 0; i--) begin
      if (port_term[i]) begin
        tohost_fire = 1'b1;
        sel_code    = port_code[i];
        sel_pc      = rvfi_i[i].pc_rdata;
      end
    end
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (rvfi_i[i].valid) n_valid = n_valid + CNT_ONE;
      if (rvfi_i[i].trap && !rvfi_i[i].valid) n_trap = n_trap + CNT_ONE;
    end
  end

  assign any_valid   = (n_valid != '0);
  assign timeout_hit = (timeout_i != '0) && (cycles_o >= timeout_i);
  // Fires on the HANG_LIMIT-th consecutive commit-free cycle.
  assign hang_hit    = (HANG_LIMIT != 0) && !any_valid &&
                       (hang_cnt == 32'(HANG_LIMIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_RUN;
      exit_kind_o <= EXIT_NONE;
      exit_code_o <= '0;
      exit_pc_o   <= '0;
      cycles_o    <= '0;
      instret_o   <= '0;
      traps_o     <= '0;
      hang_cnt    <= '0;
    end else if (clear_i) begin
      state       <= ST_RUN;
      exit_kind_o <= EXIT_NONE;
      exit_code_o <= '0;
      exit_pc_o   <= '0;
      cycles_o    <= '0;
      instret_o   <= '0;
      traps_o     <= '0;
      hang_cnt    <= '0;
    end else if (state == ST_RUN) begin
      cycles_o  <= sat_add(cycles_o, CNT_ONE);
      instret_o <= sat_add(instret_o, n_valid);
      traps_o   <= sat_add(traps_o, n_trap);
      if (any_valid)            hang_cnt <= '0;
      else if (hang_cnt != '1)  hang_cnt <= hang_cnt + 32'd1;

      if (tohost_fire) begin
        state       <= ST_DONE;
        exit_kind_o <= EXIT_TOHOST;
        exit_code_o <= sel_code;
        exit_pc_o   <= sel_pc;
      end else if (timeout_hit) begin
        state       <= ST_DONE;
        exit_kind_o <= EXIT_TIMEOUT;
      end else if (hang_hit) begin
        state       <= ST_DONE;
        exit_kind_o <= EXIT_HANG;
      end
    end
  end

  assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_rvfi_exit_monitor.sv
// Directed bench for rvfi_exit_monitor; expected exits are queued at stimulus
// time and popped when done_o rises.
module tb_rvfi_exit_monitor;
  import rvfi_pkg::*;

  localparam logic [31:0] I_SD   = 32'h0011_3023;
  localparam logic [31:0] I_SW   = 32'h0011_2023;
  localparam logic [31:0] I_CSD  = 32'h0000_E008;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;
  localparam logic [63:0] TOHOST = 64'h8000_1000;

  typedef struct {
    exit_kind_e  kind;
    logic [63:0] code;
    logic [63:0] pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  rvfi_instr_t [1:0] rvfi;
  logic [63:0]      tohost_addr;
  logic [63:0]      timeout;
  logic             clear;
  logic             done;
  exit_kind_e       exit_kind;
  logic [63:0]      exit_code;
  logic [63:0]      exit_pc;
  logic [63:0]      cycles;
  logic [63:0]      instret;
  logic [63:0]      traps;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  rvfi_exit_monitor #(
    .NR_COMMIT_PORTS (2),
    .CNT_W           (64),
    .HANG_LIMIT      (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rvfi_i        (rvfi),
    .tohost_addr_i (tohost_addr),
    .timeout_i     (timeout),
    .clear_i       (clear),
    .done_o        (done),
    .exit_kind_o   (exit_kind),
    .exit_code_o   (exit_code),
    .exit_pc_o     (exit_pc),
    .cycles_o      (cycles),
    .instret_o     (instret),
    .traps_o       (traps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hit(input int p, input logic [63:0] data);
    rvfi[p].mem_addr  = tohost_addr;
    rvfi[p].mem_wmask = 8'hff;
    rvfi[p].mem_wdata = data;
  endtask

  task automatic set_commit(input int p, input logic [31:0] insn, input logic [63:0] pc);
    rvfi[p].valid    = 1'b1;
    rvfi[p].insn     = insn;
    rvfi[p].pc_rdata = pc;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Bounded wait for done_o, then compare against the oldest queued exit.
  task automatic expect_exit(input string tag, input int budget, input int lat);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    if (sb.size() == 0) begin
      check({tag, "_queue"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_kind"}, 64'(exit_kind), 64'(e.kind));
      check({tag, "_code"}, exit_code, e.code);
      check({tag, "_pc"}, exit_pc, e.pc);
    end
  endtask

  initial begin
    rst         = 1'b1;
    clear       = 1'b0;
    timeout     = '0;
    tohost_addr = TOHOST;
    rvfi        = '0;
    step();
    step();
    check("rst_done", 64'(done), 64'd0);
    check("rst_kind", 64'(exit_kind), 64'(EXIT_NONE));
    check("rst_code", exit_code, 64'd0);
    check("rst_pc", exit_pc, 64'd0);
    check("rst_cycles", cycles, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_traps", traps, 64'd0);
    rst = 1'b0;
    check("first_cycle", cycles, 64'd0);

    // Hit on port 0, SD commit the following cycle.
    set_hit(0, 64'h1);
    step();
    rvfi = '0;
    set_commit(0, I_SD, 64'h8000_0040);
    sb.push_back('{EXIT_TOHOST, 64'h1, 64'h8000_0040});
    expect_exit("sd_next", 4, 1);
    rvfi = '0;
    repeat (3) step();
    check("hold_done", 64'(done), 64'd1);
    check("hold_code", exit_code, 64'h1);
    clear_pulse();
    check("clr_done", 64'(done), 64'd0);
    check("clr_kind", 64'(exit_kind), 64'(EXIT_NONE));
    check("clr_code", exit_code, 64'd0);
    check("clr_cycles", cycles, 64'd0);

    // Same-cycle hit plus C.SD on port 1.
    set_hit(1, 64'h3);
    set_commit(1, I_CSD, 64'h8000_0100);
    sb.push_back('{EXIT_TOHOST, 64'h3, 64'h8000_0100});
    expect_exit("csd_same", 4, 1);
    rvfi = '0;
    clear_pulse();

    // Both ports terminate together: port 0 wins.
    set_hit(0, 64'h5);
    set_commit(0, I_SD, 64'h8000_0200);
    set_hit(1, 64'h7);
    set_commit(1, I_CSD, 64'h8000_0300);
    sb.push_back('{EXIT_TOHOST, 64'h5, 64'h8000_0200});
    expect_exit("prio", 4, 1);
    rvfi = '0;
    clear_pulse();

    // Zero wdata is not a hit, and a zero tohost address disables detection.
    set_hit(0, 64'h0);
    step();
    rvfi = '0;
    set_commit(0, I_SD, 64'h8000_0500);
    step();
    step();
    check("zero_wdata", 64'(done), 64'd0);
    tohost_addr = '0;
    rvfi        = '0;
    set_hit(0, 64'h9);
    set_commit(0, I_SD, 64'h8000_0504);
    step();
    step();
    check("tohost_off", 64'(done), 64'd0);
    tohost_addr = TOHOST;
    rvfi        = '0;
    clear_pulse();

    // Timeout with steady non-store commits.
    timeout = 64'd100;
    set_commit(0, I_ADDI, 64'h8000_0600);
    clear_pulse();
    sb.push_back('{EXIT_TIMEOUT, 64'h0, 64'h0});
    expect_exit("timeout", 200, 101);
    check("to_cycles", cycles, 64'd101);
    check("to_instret", instret, 64'd101);
    repeat (5) step();
    check("to_frozen", cycles, 64'd101);
    rvfi    = '0;
    timeout = '0;
    clear_pulse();

    // Hang: a commit at count 15 defers it, the 16th idle cycle fires it.
    set_commit(0, I_ADDI, 64'h8000_0700);
    repeat (10) step();
    rvfi = '0;
    repeat (15) step();
    check("hang_15", 64'(done), 64'd0);
    set_commit(0, I_ADDI, 64'h8000_0704);
    step();
    rvfi = '0;
    check("hang_reset", 64'(done), 64'd0);
    repeat (15) step();
    check("hang_15b", 64'(done), 64'd0);
    sb.push_back('{EXIT_HANG, 64'h0, 64'h0});
    expect_exit("hang", 5, 1);
    clear_pulse();

    // Counters: 50 dual-commit cycles then 3 trap-only cycles.
    set_commit(0, I_ADDI, 64'h8000_0800);
    set_commit(1, I_ADDI, 64'h8000_0804);
    repeat (50) step();
    rvfi         = '0;
    rvfi[0].trap = 1'b1;
    repeat (3) step();
    rvfi = '0;
    check("cnt_instret", instret, 64'd100);
    check("cnt_traps", traps, 64'd3);
    check("cnt_cycles", cycles, 64'd53);
    clear_pulse();
    check("cnt_clr_instret", instret, 64'd0);
    check("cnt_clr_traps", traps, 64'd0);
    check("cnt_clr_cycles", cycles, 64'd0);
    check("cnt_clr_done", 64'(done), 64'd0);

    // SW store terminates from a pending hit.
    set_hit(0, 64'h1);
    step();
    rvfi = '0;
    set_commit(0, I_SW, 64'h8000_0400);
    sb.push_back('{EXIT_TOHOST, 64'h1, 64'h8000_0400});
    expect_exit("sw_pend", 4, 1);
    rvfi = '0;
    clear_pulse();

    // clear_i beats a same-cycle termination and drops the pending write.
    set_hit(0, 64'h2);
    step();
    rvfi = '0;
    set_commit(0, I_SW, 64'h8000_0410);
    clear = 1'b1;
    step();
    clear = 1'b0;
    rvfi  = '0;
    check("clr_wins", 64'(done), 64'd0);
    set_commit(0, I_SW, 64'h8000_0414);
    step();
    rvfi = '0;
    check("clr_pending", 64'(done), 64'd0);

    // Reset mid-run discards the latched tohost write.
    set_hit(0, 64'h1);
    step();
    rvfi = '0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_cycles", cycles, 64'd0);
    rst = 1'b0;
    set_commit(0, I_SW, 64'h8000_0420);
    step();
    step();
    rvfi = '0;
    check("rst_pending", 64'(done), 64'd0);
    check("rst_recount", cycles, 64'd2);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
